dual_7_seg: RTL and testbench
=============================

DUAL_7_SEG -- requirements
Module: dual_7_seg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk_i is the single clock, and rst_i is sampled only on the rising edge of clk_i, active when 0.
REQ-002 clk_i  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  synchronous active-low reset.
REQ-004 tens_i  input  4  BCD tens digit, unsigned; legal range 0-9.
REQ-005 ones_i  input  4  BCD ones digit, unsigned; legal range 0-9.
REQ-006 seg_tens_o  output  7  segment pattern for the tens digit.
REQ-007 seg_ones_o  output  7  segment pattern for the ones digit.
REQ-008 Segment bit order SHALL be bit0=a, bit1=b, bit2=c, bit3=d, bit4=e, bit5=f, bit6=g.
REQ-009 Segment polarity SHALL be active-high (1 = segment lit).
REQ-010 The block SHALL have no parameters.

Function
REQ-011 Each digit SHALL be decoded by an identical, independent combinational BCD-to-7-segment decoder; tens_i drives seg_tens_o and ones_i drives seg_ones_o.
REQ-012 The decode table SHALL be (hex, bits g..a):
- 0=3F, 1=06, 2=5B, 3=4F, 4=66
- 5=6D, 6=7D, 7=07, 8=7F, 9=6F
REQ-013 Input values 10-15 SHALL decode to 40 (dash: segment g only).
REQ-014 Both outputs SHALL be registered, updating on the rising edge of clk_i.
REQ-015 Latency SHALL be 1 cycle: inputs sampled at edge N appear on the outputs immediately after edge N.
REQ-016 Outputs SHALL hold their value until the next edge; there is no enable or handshake, and a decode occurs every cycle.
REQ-017 No leading-zero blanking: tens digit 0 SHALL display 3F.
REQ-018 The two digits SHALL be fully independent: an invalid value on one digit SHALL NOT affect the other digit's output.
REQ-019 Input changes between clock edges SHALL have no effect on the outputs until the next edge.

Reset
REQ-020 While rst_i=0 at a rising edge, both seg_tens_o and seg_ones_o SHALL load 7'h00 (all segments off), regardless of the inputs.
REQ-021 Reset SHALL override decoding at any time, including mid-operation; outputs go to 00 at the first edge with rst_i=0.
REQ-022 On the first edge with rst_i=1 after reset, the outputs SHALL show the decode of the inputs sampled at that edge.
REQ-023 Before the first reset edge, output values are undefined; the bench SHALL NOT check them.

Verification
REQ-024 Hold rst_i=0 for 2 edges with tens_i=5, ones_i=5 -> seg_tens_o=00, seg_ones_o=00.
REQ-025 Release reset and sweep tens_i=0,1 with ones_i=0..9 -> after each edge, outputs match the REQ-012 table, e.g. 00 -> 3F/3F, 19 -> 06/6F.
REQ-026 Apply 42, 77 and 99 -> 66/5B, 07/07 and 6F/6F respectively, each exactly one edge after the input is applied.
REQ-027 Apply tens_i=10, ones_i=11, then tens_i=15, ones_i=12 -> 40/40 both times; then tens_i=3, ones_i=12 -> 4F/40.
REQ-028 Assert rst_i=0 for one edge while displaying 99 -> outputs 00/00; release with 81 applied -> 7F/06 after the next edge.
REQ-029 Change the inputs mid-cycle (between edges) -> outputs unchanged until the next rising edge.

Source files
------------

// File: rtl/dual_7_seg.sv
// dual_7_seg
// Two-digit BCD to seven-segment display driver. Each digit has its own
// combinational decoder followed by an output register, so the outputs
// change only on the rising clock edge, one cycle after the inputs are sampled.
//
// Ports
//   clk_i       in   1  system clock, all state updates on the rising edge
//   rst_i       in   1  synchronous active-low reset (outputs -> all segments off)
//   tens_i      in   4  BCD tens digit (0-9 legal, 10-15 shown as a dash)
//   ones_i      in   4  BCD ones digit (0-9 legal, 10-15 shown as a dash)
//   seg_tens_o  out  7  tens segments, bit0=a .. bit6=g, active-high
//   seg_ones_o  out  7  ones segments, bit0=a .. bit6=g, active-high

module dual_7_seg (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
  output logic [6:0] seg_tens_o,
  output logic [6:0] seg_ones_o
);

  // Index 0 is the ones digit, index 1 is the tens digit.
  logic [3:0] w_digit [2];
  logic [6:0] w_seg   [2];
  logic [6:0] r_seg   [2];

  assign w_digit[0] = ones_i;
  assign w_digit[1] = tens_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      // Independent decoder per digit; out-of-range codes show segment g only.
      always_comb begin
        w_seg[gi] = 7'h40;
        case (w_digit[gi])
          4'd0:    w_seg[gi] = 7'h3F;
          4'd1:    w_seg[gi] = 7'h06;
          4'd2:    w_seg[gi] = 7'h5B;
          4'd3:    w_seg[gi] = 7'h4F;
          4'd4:    w_seg[gi] = 7'h66;
          4'd5:    w_seg[gi] = 7'h6D;
          4'd6:    w_seg[gi] = 7'h7D;
          4'd7:    w_seg[gi] = 7'h07;
          4'd8:    w_seg[gi] = 7'h7F;
          4'd9:    w_seg[gi] = 7'h6F;
          default: w_seg[gi] = 7'h40;
        endcase
      end

      always_ff @(posedge clk_i) begin
        if (!rst_i) begin
          r_seg[gi] <= 7'h00;
        end else begin
          r_seg[gi] <= w_seg[gi];
        end
      end
    end
  endgenerate

  assign seg_ones_o = r_seg[0];
  assign seg_tens_o = r_seg[1];

endmodule

// File: tb/tb_dual_7_seg.sv
// tb_dual_7_seg
// Self-checking bench for dual_7_seg: directed sequences followed by random
// digits and random reset pulses, compared against a table-driven reference.

module tb_dual_7_seg;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] tens_i;
  logic [3:0] ones_i;
  logic [6:0] seg_tens_o;
  logic [6:0] seg_ones_o;

  int total = 0;
  int bad   = 0;

  // Segment patterns for digits 0..9, bits g..a.
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  dual_7_seg dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .tens_i     (tens_i),
    .ones_i     (ones_i),
    .seg_tens_o (seg_tens_o),
    .seg_ones_o (seg_ones_o)
  );

  always #5 clk_i = ~clk_i;

  // Remembered expectation of the last edge, used for hold checks.
  logic [6:0] exp_tens_q;
  logic [6:0] exp_ones_q;

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    if (d > 4'd9) return 7'h40;
    return SEG_TAB[d];
  endfunction

  task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one rising edge, then check both outputs.
  task automatic step(input logic r, input logic [3:0] t, input logic [3:0] o, input string tag);
    rst_i  = r;
    tens_i = t;
    ones_i = o;
    @(posedge clk_i);
    #1;
    exp_tens_q = r ? ref_seg(t) : 7'h00;
    exp_ones_q = r ? ref_seg(o) : 7'h00;
    $display("%s rst=%0b tens=%0d ones=%0d -> seg_tens=%02h seg_ones=%02h (exp %02h/%02h)",
             tag, r, t, o, seg_tens_o, seg_ones_o, exp_tens_q, exp_ones_q);
    check({tag, "_tens"}, seg_tens_o, exp_tens_q);
    check({tag, "_ones"}, seg_ones_o, exp_ones_q);
  endtask

  initial begin
    rst_i  = 1'b0;
    tens_i = 4'd5;
    ones_i = 4'd5;

    // Reset held for two edges with non-zero inputs.
    step(1'b0, 4'd5, 4'd5, "rst0");
    step(1'b0, 4'd5, 4'd5, "rst1");

    // Sweep tens 0..1, ones 0..9.
    for (int t = 0; t < 2; t++) begin
      for (int o = 0; o < 10; o++) begin
        step(1'b1, 4'(t), 4'(o), "sweep");
      end
    end

    step(1'b1, 4'd4, 4'd2, "v42");
    step(1'b1, 4'd7, 4'd7, "v77");
    step(1'b1, 4'd9, 4'd9, "v99");

    // Invalid codes, and independence of a valid digit from an invalid one.
    step(1'b1, 4'd10, 4'd11, "inv_a");
    step(1'b1, 4'd15, 4'd12, "inv_b");
    step(1'b1, 4'd3,  4'd12, "inv_c");
    step(1'b1, 4'd12, 4'd8,  "inv_d");

    // Mid-operation reset and release.
    step(1'b1, 4'd9, 4'd9, "pre_rst");
    step(1'b0, 4'd9, 4'd9, "mid_rst");
    step(1'b1, 4'd8, 4'd1, "post_rst");

    // Inputs changed between edges must not reach the outputs early.
    for (int k = 0; k < 4; k++) begin
      tens_i = 4'($urandom_range(0, 15));
      ones_i = 4'($urandom_range(0, 15));
      #2;
      check("hold_tens", seg_tens_o, exp_tens_q);
      check("hold_ones", seg_ones_o, exp_ones_q);
      @(negedge clk_i);
      tens_i = 4'($urandom_range(0, 15));
      ones_i = 4'($urandom_range(0, 15));
      #1;
      check("hold_neg_tens", seg_tens_o, exp_tens_q);
      check("hold_neg_ones", seg_ones_o, exp_ones_q);
      step(1'b1, tens_i, ones_i, "hold_step");
    end

    // Random digits with occasional reset pulses.
    for (int n = 0; n < 200; n++) begin
      step(($urandom_range(0, 15) != 0),
           4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)),
           "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
